// File: rtl/spi_mem_if.sv
// Control-unit side of the SPI memory bridge: request handshake, op selects,
// address/data in and read data back.
interface spi_mem_if;
  logic        spi_executing;
  logic        spi_done;
  logic        rom_en;
  logic        ram_re;
  logic        ram_we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (
    output spi_executing, rom_en, ram_re, ram_we, addr, wdata,
    input  spi_done, rdata
  );

  modport slave (
    input  spi_executing, rom_en, ram_re, ram_we, addr, wdata,
    output spi_done, rdata
  );
endinterface

// File: rtl/spi_mem.sv
// SPI mode-0 bridge to a flash ROM and an SRAM: one 32-bit frame
// {cmd, addr, data} per accepted request, sclk at clk/2.
module spi_mem #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic     clk,
  input  logic     rst,
  spi_mem_if.slave bus,
  output logic     sclk,
  output logic     mosi,
  input  logic     miso,
  output logic     cs_rom_n,
  output logic     cs_ram_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP, DONE} state_t;

  state_t      state;
  logic [31:0] shift;
  logic [4:0]  bit_cnt;
  logic        phase;
  logic        op_read;
  logic        done_r;
  logic [7:0]  rdata_r;
  logic [31:0] frame;
  logic        any_op;

  assign bus.spi_done = done_r;
  assign bus.rdata    = rdata_r;

  always_comb begin
    frame  = {CMD_READ, bus.addr, 8'h00};
    any_op = bus.ram_we | bus.ram_re | bus.rom_en;
    if (bus.ram_we)
      frame = {CMD_WRITE, bus.addr, bus.wdata};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      op_read  <= 1'b0;
      done_r   <= 1'b1;
      rdata_r  <= 8'h00;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_rom_n <= 1'b1;
      cs_ram_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sclk     <= 1'b0;
          mosi     <= 1'b0;
          cs_rom_n <= 1'b1;
          cs_ram_n <= 1'b1;
          if (bus.spi_executing && done_r) begin
            done_r  <= 1'b0;
            op_read <= !bus.ram_we;
            // A request with no op selected just pulses spi_done low for a cycle.
            if (any_op) begin
              shift    <= frame;
              mosi     <= frame[31];
              bit_cnt  <= 5'd31;
              phase    <= 1'b0;
              cs_ram_n <= !(bus.ram_we | bus.ram_re);
              cs_rom_n <= bus.ram_we | bus.ram_re;
              state    <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (!phase) begin
            sclk  <= 1'b1;
            phase <= 1'b1;
          end else begin
            // Falling edge: sample miso, then put the next frame bit out.
            sclk  <= 1'b0;
            phase <= 1'b0;
            shift <= {shift[30:0], miso};
            if (bit_cnt == 5'd0) begin
              mosi  <= 1'b0;
              state <= STOP;
            end else begin
              mosi    <= shift[30];
              bit_cnt <= bit_cnt - 5'd1;
            end
          end
        end
        STOP: begin
          cs_rom_n <= 1'b1;
          cs_ram_n <= 1'b1;
          if (op_read)
            rdata_r <= shift[7:0];
          state <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_mem.md
SPI_MEM -- requirements
Module: spi_mem

Interface
Parameters (name, default, meaning):
REQ-001 CMD_READ, 8'h03, command byte for ROM and RAM reads.
REQ-002 CMD_WRITE, 8'h02, command byte for RAM writes.
Ports (name, direction, width, meaning):
REQ-003 clk input 1: single clock; all logic on posedge.
REQ-004 rst input 1: reset, synchronous, active-low.
REQ-005 spi_executing input 1: request level from the control unit.
REQ-006 spi_done output 1: completion flag; idles high; low while busy.
REQ-007 rom_en input 1: ROM read (ROMO).
REQ-008 ram_re input 1: RAM read (RAMO).
REQ-009 ram_we input 1: RAM write (RAMI).
REQ-010 addr input 16: byte address (pc for ROM, RAM address otherwise).
REQ-011 wdata input 8: RAM write data.
REQ-012 rdata output 8: last byte read.
REQ-013 sclk output 1: SPI clock, mode 0, clk/2.
REQ-014 mosi output 1: serial data out, MSB first.
REQ-015 miso input 1: serial data in.
REQ-016 cs_rom_n output 1: flash chip select, active-low.
REQ-017 cs_ram_n output 1: SRAM chip select, active-low.

Function
REQ-018 States: IDLE, SHIFT, STOP, DONE.
REQ-019 In IDLE with spi_done=1, a high spi_executing at posedge E0 is accepted; it is ignored in every other state.
REQ-020 At E0, latch op, addr and wdata; spi_done<=0; go to SHIFT.
REQ-021 Op priority is ram_we > ram_re > rom_en. Only the selected device's cs is asserted.
REQ-022 Frame is 32 bits: {cmd[7:0], addr[15:0], data[7:0]}. Data is wdata for writes and 8'h00 for reads.
REQ-023 At E0, drive cs low and sclk=0, and put frame bit 31 on mosi.
REQ-024 At odd edge E(2k+1), k=0..31: sclk<=1.
REQ-025 At even edge E(2k+2): sclk<=0, sample miso into the shift register, and present the next bit on mosi.
REQ-026 Change mosi only while sclk is low.
REQ-027 At E64, after the last sample, go to STOP. cs stays low during STOP.
REQ-028 At E65, deassert both cs high and go to DONE.
REQ-029 For reads, rdata<=the last 8 sampled bits at E65. Writes leave rdata unchanged.
REQ-030 At E66, spi_done<=1 and go to IDLE, so spi_done rises exactly 66 cycles after E0.
REQ-031 The control unit detects the rising edge of spi_done. spi_done stays high until the next acceptance.
REQ-032 A new request may be accepted on the cycle after spi_done rises.
REQ-033 No-op request (rom_en=ram_re=ram_we=0): no cs, sclk or mosi activity. spi_done is low for exactly one cycle (E0 to E1), then rises at E1.
REQ-034 In IDLE: sclk=0, mosi=0, both cs high.
REQ-035 Changes to addr, wdata and op inputs after E0 do not affect the active frame.
REQ-036 The bit counter is 5 bits plus a phase bit. It does not wrap past bit 0; the transition to STOP ends the frame.

Reset
REQ-037 While rst=0 at posedge: state=IDLE, spi_done=1, rdata=8'h00, sclk=0, mosi=0, cs_rom_n=1, cs_ram_n=1, counters cleared.
REQ-038 Reset mid-frame aborts the frame immediately on that edge. cs deasserts with no partial write completion guaranteed, and rdata is cleared.

Verification
REQ-039 ROM read: rom_en=1, addr=16'h0123, flash model returns 8'hA5. Required: cs_rom_n low, mosi=03 01 23 00, rdata=8'hA5, spi_done rises 66 cycles after E0.
REQ-040 RAM write: ram_we=1, addr=16'hFFFF, wdata=8'h5C. Required: cs_ram_n low, mosi=02 FF FF 5C, rdata unchanged, model RAM[FFFF]=5C.
REQ-041 Priority: rom_en=ram_re=1, addr=16'h0010, RAM model returns 8'h3C. Required: only cs_ram_n asserted, command 03, rdata=8'h3C.
REQ-042 No-op request: all op inputs 0 with spi_executing=1. Required: no cs or sclk toggling, spi_done low for one cycle.
REQ-043 Reset at cycle 20 of a RAM write. Required: outputs return to reset values on that edge; a following ROM read completes normally in 66 cycles.
REQ-044 Back-to-back: spi_executing held high continuously. Required: a second frame is accepted one cycle after spi_done rises, with both cs high for at least 2 cycles between frames.
